tag_ram_sweep: RTL and testbench



---
 rtl/tag_ram_sweep.sv | 147 ++++++++++++++
 tb/tb_tag_ram_sweep.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tag_ram_sweep.sv
// Single-port DIFT tag RAM (TAG_WIDTH bits per data byte) with a one-word-per-cycle clear sweep.
// Define TAG_RAM_WR_THROUGH_EN to return the merged word on writes instead of the pre-write word.
module tag_ram_sweep #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WORDS  = 32768,
  parameter int TAG_WIDTH  = 1
) (
  input  logic                                clk,
  input  logic                                rst_i,
  input  logic                                en_i,
  input  logic [ADDR_WIDTH-1:0]               addr_i,
  input  logic                                we_i,
  input  logic [DATA_WIDTH/8-1:0]             be_i,
  input  logic [TAG_WIDTH-1:0]                wdata_i,
  output logic                                gnt_o,
  output logic                                rvalid_o,
  output logic [(DATA_WIDTH/8)*TAG_WIDTH-1:0] rdata_o,
  input  logic                                clr_req_i,
  output logic                                busy_o
);

  localparam int NB     = DATA_WIDTH / 8;
  localparam int NB_LOG = $clog2(NB);
  localparam int IW     = ADDR_WIDTH - NB_LOG;
  localparam int WORDS  = NUM_WORDS / NB;
  localparam int PW     = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int RW     = NB * TAG_WIDTH;

  typedef enum logic {
    ST_SWEEP,
    ST_IDLE
  } state_e;

  state_e          state_q;
  logic [PW-1:0]   ptr_q;
  logic            busy_q;
  logic            rvalid_q;
  logic [RW-1:0]   rdata_q;
  logic [RW-1:0]   rdata_d;

  logic [RW-1:0]   mem [WORDS];

  logic [IW-1:0]   word_idx;
  logic [PW-1:0]   mem_idx;
  logic            in_range;
  logic [RW-1:0]   old_word;
  logic [RW-1:0]   merged_word;
  logic [RW-1:0]   wr_return;
  logic            sweep_we;
  logic            acc_we;

  assign word_idx = addr_i[ADDR_WIDTH-1:NB_LOG];
  assign mem_idx  = word_idx[PW-1:0];
  assign in_range = ({1'b0, word_idx} < (IW+1)'(WORDS));
  assign old_word = mem[mem_idx];

  generate
    if (NB_LOG > 0) begin : g_lsb
      logic unused_lsb;
      assign unused_lsb = ^addr_i[NB_LOG-1:0];
    end
  endgenerate

  always_comb begin
    merged_word = old_word;
    for (int i = 0; i < NB; i++) begin
      if (be_i[i]) merged_word[i*TAG_WIDTH +: TAG_WIDTH] = wdata_i;
    end
  end

`ifdef TAG_RAM_WR_THROUGH_EN
  assign wr_return = merged_word;
`else
  assign wr_return = old_word;
`endif

  assign gnt_o    = en_i & ~busy_q;
  assign sweep_we = (state_q == ST_SWEEP);
  assign acc_we   = gnt_o & we_i & in_range;

  // Out-of-range accesses still complete, but always return zero.
  always_comb begin
    rdata_d = rdata_q;
    if (gnt_o) begin
      if (!in_range)  rdata_d = '0;
      else if (we_i)  rdata_d = wr_return;
      else            rdata_d = old_word;
    end
  end

  // NOTE: the array has no reset branch on purpose; zeroing a RAM in one cycle
  // is not implementable, so the sweep FSM clears it word by word instead.
  always_ff @(posedge clk) begin
    if (sweep_we)    mem[ptr_q]   <= '0;
    else if (acc_we) mem[mem_idx] <= merged_word;
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_SWEEP;
      ptr_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        ST_SWEEP: begin
          if (ptr_q == PW'(WORDS - 1)) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            ptr_q <= ptr_q + PW'(1);
          end
        end
        ST_IDLE: begin
          if (clr_req_i) begin
            state_q <= ST_SWEEP;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_SWEEP;
          ptr_q   <= '0;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= gnt_o;
      rdata_q  <= rdata_d;
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign busy_o   = busy_q;

endmodule

// File: tb/tb_tag_ram_sweep.sv
// Directed bench for tag_ram_sweep: default instance (TAG_WIDTH=1, 8192 words)
// plus a small TAG_WIDTH=2 instance for multi-bit tag packing.
module tb_tag_ram_sweep;

`ifdef TAG_RAM_WR_THROUGH_EN
  localparam bit WT = 1'b1;
`else
  localparam bit WT = 1'b0;
`endif
  localparam int WORDS = 8192;

  logic        clk;
  logic        rst;
  logic        en, we, wdata, clr_req;
  logic [15:0] addr;
  logic [3:0]  be;
  logic        gnt, rvalid, busy;
  logic [3:0]  rdata;

  logic        en2, we2, clr2;
  logic [15:0] addr2;
  logic [3:0]  be2;
  logic [1:0]  wdata2;
  logic        gnt2, rvalid2, busy2;
  logic [7:0]  rdata2;

  int checks = 0;
  int errors = 0;

  tag_ram_sweep u_dut (
    .clk(clk), .rst_i(rst), .en_i(en), .addr_i(addr), .we_i(we), .be_i(be),
    .wdata_i(wdata), .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata),
    .clr_req_i(clr_req), .busy_o(busy)
  );

  tag_ram_sweep #(.NUM_WORDS(256), .TAG_WIDTH(2)) u_dut2 (
    .clk(clk), .rst_i(rst), .en_i(en2), .addr_i(addr2), .we_i(we2), .be_i(be2),
    .wdata_i(wdata2), .gnt_o(gnt2), .rvalid_o(rvalid2), .rdata_o(rdata2),
    .clr_req_i(clr2), .busy_o(busy2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic access(input logic w, input logic [15:0] a, input logic [3:0] b,
                        input logic d, output logic g, output logic v, output logic [3:0] r);
    @(negedge clk);
    en = 1'b1; we = w; addr = a; be = b; wdata = d;
    #1 g = gnt;
    @(posedge clk);
    #1 v = rvalid; r = rdata;
    en = 1'b0; we = 1'b0;
  endtask

  // Counts rising edges until busy falls; caller samples just after an edge or at a negedge.
  task automatic run_sweep(input bit pulse_clr, output int n, output int ghits, output int vhits);
    n = 0; ghits = 0; vhits = 0;
    while (busy === 1'b1 && n < 20000) begin
      if (gnt !== 1'b0) ghits++;
      clr_req = pulse_clr && (n == 50);
      @(posedge clk);
      #1 n++;
      if (rvalid !== 1'b0) vhits++;
    end
    clr_req = 1'b0;
  endtask

  task automatic test_reset();
    int n, gh, vh;
    rst = 1'b1; en = 1'b1; we = 1'b0; addr = '0; be = '0; wdata = 1'b0; clr_req = 1'b0;
    en2 = 1'b0; we2 = 1'b0; addr2 = '0; be2 = '0; wdata2 = '0; clr2 = 1'b0;
    #3;
    if ({busy, gnt, rvalid, rdata} !== {1'b1, 1'b0, 1'b0, 4'h0}) begin
      errors++;
      $display("FAIL reset_values: busy/gnt/rvalid/rdata=%b/%b/%b/%h want 1/0/0/0", busy, gnt, rvalid, rdata);
    end
    checks++;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    run_sweep(1'b0, n, gh, vh);
    if (n !== WORDS) begin
      errors++; $display("FAIL reset_sweep_len: edges=%0d want %0d", n, WORDS);
    end
    checks++;
    if (gh !== 0) begin
      errors++; $display("FAIL reset_sweep_gnt: gnt high %0d times want 0", gh);
    end
    checks++;
    @(negedge clk); en = 1'b0;
  endtask

  task automatic test_read_zero();
    logic g, v; logic [3:0] r;
    access(1'b0, 16'h0000, 4'h0, 1'b0, g, v, r);
    if ({g, v, r} !== 6'b11_0000) begin
      errors++; $display("FAIL read_0000: gnt/rvalid/rdata=%b/%b/%h want 1/1/0", g, v, r);
    end
    checks++;
    access(1'b0, 16'h7FFC, 4'h0, 1'b0, g, v, r);
    if ({g, v, r} !== 6'b11_0000) begin
      errors++; $display("FAIL read_7ffc: gnt/rvalid/rdata=%b/%b/%h want 1/1/0", g, v, r);
    end
    checks++;
    @(posedge clk); #1;
    if (rvalid !== 1'b0) begin
      errors++; $display("FAIL rvalid_idle: rvalid=%b want 0", rvalid);
    end
    checks++;
  endtask

  task automatic test_byte_write();
    logic g, v; logic [3:0] r;
    access(1'b1, 16'h0010, 4'b0101, 1'b1, g, v, r);
    if ({g, v, r} !== {2'b11, (WT ? 4'b0101 : 4'b0000)}) begin
      errors++; $display("FAIL write_0010: gnt/rvalid/rdata=%b/%b/%b want 1/1/%b", g, v, r, (WT ? 4'b0101 : 4'b0000));
    end
    checks++;
    access(1'b0, 16'h0010, 4'h0, 1'b0, g, v, r);
    if (r !== 4'b0101) begin
      errors++; $display("FAIL read_0010_a: rdata=%b want 0101", r);
    end
    checks++;
    access(1'b1, 16'h0011, 4'b0010, 1'b1, g, v, r);
    if (r !== (WT ? 4'b0111 : 4'b0101)) begin
      errors++; $display("FAIL write_0011: rdata=%b want %b", r, (WT ? 4'b0111 : 4'b0101));
    end
    checks++;
    access(1'b0, 16'h0010, 4'h0, 1'b0, g, v, r);
    if (r !== 4'b0111) begin
      errors++; $display("FAIL read_0010_b: rdata=%b want 0111", r);
    end
    checks++;
  endtask

  task automatic test_out_of_range();
    logic g, v; logic [3:0] r;
    access(1'b1, 16'h8000, 4'hF, 1'b1, g, v, r);
    if ({g, v, r} !== 6'b11_0000) begin
      errors++; $display("FAIL oor_write: gnt/rvalid/rdata=%b/%b/%h want 1/1/0", g, v, r);
    end
    checks++;
    access(1'b0, 16'h0000, 4'h0, 1'b0, g, v, r);
    if (r !== 4'h0) begin
      errors++; $display("FAIL oor_alias: word0 rdata=%h want 0", r);
    end
    checks++;
    access(1'b0, 16'h0010, 4'h0, 1'b0, g, v, r);
    access(1'b0, 16'hFFFC, 4'h0, 1'b0, g, v, r);
    if ({v, r} !== 5'b1_0000) begin
      errors++; $display("FAIL oor_read: rvalid/rdata=%b/%h want 1/0", v, r);
    end
    checks++;
  endtask

  task automatic test_write_mode();
    logic g, v; logic [3:0] r;
    access(1'b1, 16'h0100, 4'hF, 1'b1, g, v, r);
    if (r !== (WT ? 4'hF : 4'h0)) begin
      errors++; $display("FAIL wmode_first: rdata=%b want %b", r, (WT ? 4'hF : 4'h0));
    end
    checks++;
    access(1'b1, 16'h0100, 4'b0001, 1'b0, g, v, r);
    if (r !== (WT ? 4'b1110 : 4'b1111)) begin
      errors++; $display("FAIL wmode_second: rdata=%b want %b", r, (WT ? 4'b1110 : 4'b1111));
    end
    checks++;
    access(1'b0, 16'h0100, 4'h0, 1'b0, g, v, r);
    if (r !== 4'b1110) begin
      errors++; $display("FAIL wmode_read: rdata=%b want 1110", r);
    end
    checks++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] a [3];
    logic [3:0]  e [3];
    a[0] = 16'h0000; a[1] = 16'h0010; a[2] = 16'h0100;
    e[0] = 4'b0000;  e[1] = 4'b0111;  e[2] = 4'b1110;
    @(negedge clk);
    en = 1'b1; we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      addr = a[i];
      @(posedge clk); #1;
      if ({rvalid, rdata} !== {1'b1, e[i]}) begin
        errors++; $display("FAIL b2b_%0d: rvalid/rdata=%b/%b want 1/%b", i, rvalid, rdata, e[i]);
      end
      checks++;
    end
    en = 1'b0;
    @(posedge clk); #1;
    if ({rvalid, rdata} !== 5'b0_1110) begin
      errors++; $display("FAIL b2b_hold: rvalid/rdata=%b/%b want 0/1110", rvalid, rdata);
    end
    checks++;
  endtask

  task automatic test_tag_width2();
    @(negedge clk);
    en2 = 1'b1; we2 = 1'b1; addr2 = 16'h0020; be2 = 4'b1000; wdata2 = 2'b10;
    @(posedge clk); #1 en2 = 1'b0;
    if ({rvalid2, rdata2} !== {1'b1, (WT ? 8'h80 : 8'h00)}) begin
      errors++; $display("FAIL tw2_write: rvalid/rdata=%b/%h want 1/%h", rvalid2, rdata2, (WT ? 8'h80 : 8'h00));
    end
    checks++;
    @(negedge clk);
    en2 = 1'b1; we2 = 1'b1; be2 = 4'b0001; wdata2 = 2'b01;
    @(posedge clk); #1 en2 = 1'b0;
    @(negedge clk);
    en2 = 1'b1; we2 = 1'b0;
    @(posedge clk); #1 en2 = 1'b0;
    if (rdata2 !== 8'b10_00_00_01) begin
      errors++; $display("FAIL tw2_read: rdata=%b want 10000001", rdata2);
    end
    checks++;
  endtask

  task automatic test_clear();
    int n, gh, vh;
    logic g, v; logic [3:0] r;
    @(negedge clk);
    en = 1'b1; we = 1'b1; addr = 16'h0200; be = 4'hF; wdata = 1'b1; clr_req = 1'b1;
    #1;
    if (gnt !== 1'b1) begin
      errors++; $display("FAIL clr_grant: gnt=%b want 1", gnt);
    end
    checks++;
    @(posedge clk); #1;
    clr_req = 1'b0; we = 1'b0; addr = 16'h0010;
    if ({busy, rvalid, rdata} !== {2'b11, (WT ? 4'hF : 4'h0)}) begin
      errors++; $display("FAIL clr_start: busy/rvalid/rdata=%b/%b/%h want 1/1/%h", busy, rvalid, rdata, (WT ? 4'hF : 4'h0));
    end
    checks++;
    run_sweep(1'b1, n, gh, vh);
    en = 1'b0;
    if (n !== WORDS) begin
      errors++; $display("FAIL clr_sweep_len: edges=%0d want %0d", n, WORDS);
    end
    checks++;
    if (gh !== 0 || vh !== 0) begin
      errors++; $display("FAIL clr_sweep_stall: gnt hits=%0d rvalid hits=%0d want 0/0", gh, vh);
    end
    checks++;
    access(1'b0, 16'h0200, 4'h0, 1'b0, g, v, r);
    if ({g, v, r} !== 6'b11_0000) begin
      errors++; $display("FAIL clr_word200: gnt/rvalid/rdata=%b/%b/%h want 1/1/0", g, v, r);
    end
    checks++;
    access(1'b0, 16'h0010, 4'h0, 1'b0, g, v, r);
    if (r !== 4'h0) begin
      errors++; $display("FAIL clr_word010: rdata=%h want 0", r);
    end
    checks++;
    access(1'b0, 16'h0100, 4'h0, 1'b0, g, v, r);
    if (r !== 4'h0) begin
      errors++; $display("FAIL clr_word100: rdata=%h want 0", r);
    end
    checks++;
  endtask

  task automatic test_reset_mid_sweep();
    int n, gh, vh;
    logic g, v; logic [3:0] r;
    access(1'b1, 16'h0010, 4'b0001, 1'b1, g, v, r);
    access(1'b0, 16'h0010, 4'h0, 1'b0, g, v, r);
    @(negedge clk); clr_req = 1'b1;
    @(posedge clk); #1 clr_req = 1'b0; en = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    if ({busy, gnt, rdata} !== {2'b10, 4'b0001}) begin
      errors++; $display("FAIL mid_hold: busy/gnt/rdata=%b/%b/%b want 1/0/0001", busy, gnt, rdata);
    end
    checks++;
    @(negedge clk); #2 rst = 1'b1;
    #1;
    if ({busy, gnt, rvalid, rdata} !== {3'b100, 4'h0}) begin
      errors++; $display("FAIL mid_reset: busy/gnt/rvalid/rdata=%b/%b/%b/%h want 1/0/0/0", busy, gnt, rvalid, rdata);
    end
    checks++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_sweep(1'b0, n, gh, vh);
    en = 1'b0;
    if (n !== WORDS || gh !== 0) begin
      errors++; $display("FAIL mid_resweep: edges=%0d gnt hits=%0d want %0d/0", n, gh, WORDS);
    end
    checks++;
    access(1'b0, 16'h0010, 4'h0, 1'b0, g, v, r);
    if ({v, r} !== 5'b1_0000) begin
      errors++; $display("FAIL mid_cleared: rvalid/rdata=%b/%h want 1/0", v, r);
    end
    checks++;
  endtask

  initial begin
    test_reset();
    test_read_zero();
    test_byte_write();
    test_out_of_range();
    test_write_mode();
    test_back_to_back();
    test_tag_width2();
    test_clear();
    test_reset_mid_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
